// File: rtl/register_tree_pq.sv
// register_tree_pq: register-based binary-heap priority queue.
// Enqueue/dequeue/replace with a fixed-latency sift (one heap level per cycle).
// The root is mirrored into a registered o_data (0 when empty).
module register_tree_pq #(
  parameter int QUEUE_SIZE = 7,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_MODE   = 1
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            i_enqueue,
  input  logic                            i_dequeue,
  input  logic                            i_replace,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_ready,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_valid,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                            o_full,
  output logic                            o_empty,
  output logic                            o_drop
);
  localparam int TREE_DEPTH = $clog2(QUEUE_SIZE + 1);
  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int IW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam logic [CW-1:0] LAST_LVL = CW'((TREE_DEPTH > 1) ? TREE_DEPTH - 2 : 0);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SIFT_UP   = 2'd1;
  localparam logic [1:0] SIFT_DOWN = 2'd2;

  logic [DATA_WIDTH-1:0] node_q [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] node_d [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] vld_q, vld_d;
  logic [CW-1:0]         count_q, count_d, lvl_q, lvl_d;
  logic [IW-1:0]         cur_q, cur_d;
  logic [1:0]            state_q, state_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  rep, empty, full, child_wins;
  logic [IW-1:0]         par_i, lft_i, rgt_i, bst_i, ins_i, last_i;
  logic [DATA_WIDTH-1:0] tmp;
  logic                  tmpv;
  int                    ci, li;

  // Strict comparison; ties never win, so equal keys never swap.
  function automatic logic wins(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return (MAX_MODE != 0) ? (a > b) : (a < b);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(QUEUE_SIZE));
  assign o_ready = (state_q == IDLE);
  assign o_valid = o_ready & ~empty;
  assign o_count = count_q;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_drop  = drop_q;
  assign o_data  = data_q;

  // Request decode in IDLE and one heap level of sifting per busy cycle.
  always_comb begin
    node_d     = node_q;
    vld_d      = vld_q;
    count_d    = count_q;
    lvl_d      = lvl_q;
    cur_d      = cur_q;
    state_d    = state_q;
    drop_d     = 1'b0;
    rep        = i_replace | (i_enqueue & i_dequeue);
    ins_i      = IW'(count_q);
    last_i     = IW'(count_q - CW'(1));
    ci         = int'(cur_q);
    li         = 2 * ci + 1;
    par_i      = IW'((ci > 0) ? (ci - 1) / 2 : 0);
    lft_i      = IW'((li < QUEUE_SIZE) ? li : 0);
    rgt_i      = IW'((li < QUEUE_SIZE) ? li + 1 : 0);
    bst_i      = lft_i;
    child_wins = 1'b0;
    tmp        = '0;
    tmpv       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rep && !empty) begin
          node_d[0] = i_data;
          if (TREE_DEPTH > 1) begin
            state_d = SIFT_DOWN;
            cur_d   = '0;
            lvl_d   = '0;
          end
        end else if (rep || i_enqueue) begin
          if (full) begin
            drop_d = 1'b1;
          end else begin
            node_d[ins_i] = i_data;
            vld_d[ins_i]  = 1'b1;
            count_d       = count_q + CW'(1);
            if (TREE_DEPTH > 1) begin
              state_d = SIFT_UP;
              cur_d   = ins_i;
              lvl_d   = '0;
            end
          end
        end else if (i_dequeue) begin
          if (empty) begin
            drop_d = 1'b1;
          end else begin
            // Root takes the last entry first, then the last slot is cleared;
            // with a single entry this leaves the queue empty.
            node_d[0]      = node_q[last_i];
            vld_d[last_i]  = 1'b0;
            count_d        = count_q - CW'(1);
            if (TREE_DEPTH > 1) begin
              state_d = SIFT_DOWN;
              cur_d   = '0;
              lvl_d   = '0;
            end
          end
        end
      end
      SIFT_UP: begin
        if (ci > 0) begin
          child_wins = vld_q[cur_q] && (!vld_q[par_i] || wins(node_q[cur_q], node_q[par_i]));
          if (child_wins) begin
            node_d[par_i] = node_q[cur_q];
            node_d[cur_q] = node_q[par_i];
            vld_d[par_i]  = vld_q[cur_q];
            vld_d[cur_q]  = vld_q[par_i];
          end
        end
        cur_d = par_i;
      end
      SIFT_DOWN: begin
        if (li < QUEUE_SIZE) begin
          // Right child is chosen only if it strictly beats the left one.
          if (vld_q[rgt_i] && (!vld_q[lft_i] || wins(node_q[rgt_i], node_q[lft_i])))
            bst_i = rgt_i;
          child_wins = vld_q[bst_i] && (!vld_q[cur_q] || wins(node_q[bst_i], node_q[cur_q]));
          if (child_wins) begin
            tmp           = node_q[cur_q];
            tmpv          = vld_q[cur_q];
            node_d[cur_q] = node_q[bst_i];
            vld_d[cur_q]  = vld_q[bst_i];
            node_d[bst_i] = tmp;
            vld_d[bst_i]  = tmpv;
            cur_d         = bst_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Fixed-length walk: busy for exactly TREE_DEPTH-1 cycles.
    if (state_q != IDLE) begin
      if (lvl_q == LAST_LVL) state_d = IDLE;
      else                   lvl_d   = lvl_q + CW'(1);
    end
    data_d = vld_d[0] ? node_d[0] : '0;
  end

  // State registers; reset empties the queue and aborts any sift.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < QUEUE_SIZE; i++) node_q[i] <= '0;
      vld_q   <= '0;
      count_q <= '0;
      lvl_q   <= '0;
      cur_q   <= '0;
      state_q <= IDLE;
      drop_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) node_q[i] <= node_d[i];
      vld_q   <= vld_d;
      count_q <= count_d;
      lvl_q   <= lvl_d;
      cur_q   <= cur_d;
      state_q <= state_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_register_tree_pq.sv
// Bench for register_tree_pq: a max-mode and a min-mode instance share inputs.
// Directed table vectors, a mid-sift reset sequence and a random run against
// a reference queue model.
module tb_register_tree_pq;
  localparam int QS = 7;
  localparam int DW = 32;
  localparam int CW = 3;
  localparam int LAT = 2;
  localparam int OP_ENQ = 0, OP_DEQ = 1, OP_REP = 2, OP_BOTH = 3, OP_RST = 4;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic enq = 1'b0, deq = 1'b0, rep = 1'b0;
  logic [DW-1:0] din = '0;

  logic a_ready, a_valid, a_full, a_empty, a_drop;
  logic b_ready, b_valid, b_full, b_empty, b_drop;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] a_count, b_count;

  logic sel = 1'b0;
  logic t_ready, t_valid, t_full, t_empty, t_drop;
  logic [DW-1:0] t_data;
  logic [CW-1:0] t_count;

  always #5 CLK = ~CLK;

  register_tree_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_MODE(1)) u_max (
    .CLK(CLK), .RSTn(RSTn), .i_enqueue(enq), .i_dequeue(deq), .i_replace(rep),
    .i_data(din), .o_ready(a_ready), .o_data(a_data), .o_valid(a_valid),
    .o_count(a_count), .o_full(a_full), .o_empty(a_empty), .o_drop(a_drop));

  register_tree_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_MODE(0)) u_min (
    .CLK(CLK), .RSTn(RSTn), .i_enqueue(enq), .i_dequeue(deq), .i_replace(rep),
    .i_data(din), .o_ready(b_ready), .o_data(b_data), .o_valid(b_valid),
    .o_count(b_count), .o_full(b_full), .o_empty(b_empty), .o_drop(b_drop));

  // Route the instance under test to the checker.
  always_comb begin
    t_ready = sel ? b_ready : a_ready;
    t_valid = sel ? b_valid : a_valid;
    t_full  = sel ? b_full  : a_full;
    t_empty = sel ? b_empty : a_empty;
    t_drop  = sel ? b_drop  : a_drop;
    t_data  = sel ? b_data  : a_data;
    t_count = sel ? b_count : a_count;
  end

  typedef struct { int op; logic [DW-1:0] d; logic [DW-1:0] top; int cnt; bit drop; } vec_t;
  typedef struct { logic [DW-1:0] top; int cnt; bit drop; } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   mx[$];
  int   mn[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int op, input int d, input int top, input int cnt, input bit drop);
    vec_t v;
    v.op = op; v.d = DW'(d); v.top = DW'(top); v.cnt = cnt; v.drop = drop;
    tbl.push_back(v);
  endtask

  task automatic chk_state(input string nm, input logic [DW-1:0] top, input int cnt);
    chk({nm, " data"},  t_data, top);
    chk({nm, " count"}, DW'(t_count), DW'(cnt));
    chk({nm, " full"},  DW'(t_full), DW'(cnt == QS));
    chk({nm, " empty"}, DW'(t_empty), DW'(cnt == 0));
    chk({nm, " valid"}, DW'(t_valid), DW'(cnt != 0));
    chk({nm, " ready"}, DW'(t_ready), 1);
  endtask

  task automatic do_reset(input string nm);
    @(negedge CLK);
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk_state(nm, '0, 0);
    chk({nm, " drop"}, DW'(t_drop), 0);
  endtask

  // Drive one operation, push its expectation, then pop and compare once idle.
  task automatic do_op(input int op, input logic [DW-1:0] d, input logic [DW-1:0] et,
                       input int ec, input bit ed, input string nm);
    exp_t e;
    int   lat;
    logic drop_seen;
    e.top = et; e.cnt = ec; e.drop = ed;
    sb.push_back(e);
    @(negedge CLK);
    lat = 0;
    while (!t_ready && lat < 50) begin lat++; @(negedge CLK); end
    if (!t_ready) begin
      total++; bad++;
      $display("FAIL %s: ready timeout before issue", nm);
    end
    enq = (op == OP_ENQ) || (op == OP_BOTH);
    deq = (op == OP_DEQ) || (op == OP_BOTH);
    rep = (op == OP_REP);
    din = d;
    @(posedge CLK);
    #1;
    enq = 1'b0; deq = 1'b0; rep = 1'b0;
    @(negedge CLK);
    drop_seen = t_drop;
    lat = 0;
    while (!t_ready && lat < 50) begin lat++; @(negedge CLK); end
    e = sb.pop_front();
    chk({nm, " drop"}, DW'(drop_seen), DW'(e.drop));
    chk({nm, " latency"}, DW'(lat), DW'(e.drop ? 0 : LAT));
    chk_state(nm, e.top, e.cnt);
  endtask

  function automatic int best_idx(input int q[$], input bit maxm);
    int b = 0;
    for (int i = 1; i < q.size(); i++)
      if (maxm ? (q[i] > q[b]) : (q[i] < q[b])) b = i;
    return b;
  endfunction

  // Reference model: plain unordered queues, best element found by scan.
  task automatic mdl(input int op, input int d, output bit drop);
    drop = 1'b0;
    if ((op == OP_REP || op == OP_BOTH) && mx.size() > 0) begin
      mx.delete(best_idx(mx, 1'b1)); mx.push_back(d);
      mn.delete(best_idx(mn, 1'b0)); mn.push_back(d);
    end else if (op != OP_DEQ) begin
      if (mx.size() == QS) drop = 1'b1;
      else begin mx.push_back(d); mn.push_back(d); end
    end else begin
      if (mx.size() == 0) drop = 1'b1;
      else begin mx.delete(best_idx(mx, 1'b1)); mn.delete(best_idx(mn, 1'b0)); end
    end
  endtask

  initial begin
    // Directed vectors for the max-mode instance.
    add(OP_RST, 0, 0, 0, 0);
    add(OP_ENQ, 30, 30, 1, 0);
    add(OP_ENQ, 10, 30, 2, 0);
    add(OP_ENQ, 50, 50, 3, 0);
    add(OP_ENQ, 20, 50, 4, 0);
    add(OP_DEQ, 0, 30, 3, 0);
    add(OP_DEQ, 0, 20, 2, 0);
    add(OP_DEQ, 0, 10, 1, 0);
    add(OP_DEQ, 0, 0, 0, 0);
    add(OP_DEQ, 0, 0, 0, 1);
    for (int v = 1; v <= 7; v++) add(OP_ENQ, v, v, v, 0);
    add(OP_ENQ, 99, 7, 7, 1);
    add(OP_REP, 3, 6, 7, 0);
    add(OP_RST, 0, 0, 0, 0);
    add(OP_REP, 9, 9, 1, 0);
    add(OP_DEQ, 0, 0, 0, 0);
    add(OP_ENQ, 5, 5, 1, 0);
    add(OP_ENQ, 8, 8, 2, 0);
    add(OP_BOTH, 100, 100, 2, 0);
    add(OP_BOTH, 1, 5, 2, 0);
    add(OP_ENQ, 5, 5, 3, 0);
    add(OP_DEQ, 0, 5, 2, 0);

    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].op == OP_RST) do_reset($sformatf("vec%0d reset", i));
      else do_op(tbl[i].op, tbl[i].d, tbl[i].top, tbl[i].cnt, tbl[i].drop, $sformatf("vec%0d", i));
    end

    // Min-mode ordering, then reset in the middle of a sift-up.
    sel = 1'b1;
    do_reset("min reset");
    do_op(OP_ENQ, 40, 40, 1, 0, "min enq40");
    do_op(OP_ENQ, 15, 15, 2, 0, "min enq15");
    do_op(OP_ENQ, 25, 15, 3, 0, "min enq25");
    @(negedge CLK);
    enq = 1'b1; din = 20;
    @(posedge CLK);
    #1;
    enq = 1'b0;
    chk("mid-sift busy", DW'(t_ready), 0);
    #1;
    RSTn = 1'b0;
    #1;
    chk_state("mid-sift reset", '0, 0);
    chk("mid-sift reset drop", DW'(t_drop), 0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);
    chk_state("after mid-sift reset", '0, 0);

    // Random run; both instances are checked against their own model.
    sel = 1'b0;
    do_reset("rnd reset");
    mx.delete(); mn.delete();
    for (int n = 0; n < 200; n++) begin
      int op, d;
      bit dr;
      op = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 63));
      mdl(op, d, dr);
      do_op(op, DW'(d), mx.size() ? DW'(mx[best_idx(mx, 1'b1)]) : '0, mx.size(), dr,
            $sformatf("rnd%0d max", n));
      chk($sformatf("rnd%0d min data", n), b_data, mn.size() ? DW'(mn[best_idx(mn, 1'b0)]) : '0);
      chk($sformatf("rnd%0d min count", n), DW'(b_count), DW'(mn.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
